// File: rtl/dbg_pkg.sv
// Shared debug definitions: command codes, response bytes and the bridge FSM
// state encoding. Also used by the core-side debug module.
package dbg_pkg;

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CMD_W-1:0] CMD_HALT       = 3'd1;
  localparam logic [CMD_W-1:0] CMD_RESUME     = 3'd2;
  localparam logic [CMD_W-1:0] CMD_READ_REG   = 3'd3;
  localparam logic [CMD_W-1:0] CMD_WRITE_REG  = 3'd4;
  localparam logic [CMD_W-1:0] CMD_RESET_CORE = 3'd5;

  localparam logic [BYTE_W-1:0] RESP_ACK = 8'hAA;
  localparam logic [BYTE_W-1:0] RESP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    ISSUE,
    WAIT_DONE,
    SEND
  } state_t;

  // True when a raw host byte encodes one of the five defined commands.
  function automatic logic is_cmd(input logic [BYTE_W-1:0] b);
    logic [CMD_W-1:0] c;
    c = b[CMD_W-1:0];
    return (b[BYTE_W-1:CMD_W] == 5'd0) &&
           ((c == CMD_HALT) || (c == CMD_RESUME) || (c == CMD_READ_REG) ||
            (c == CMD_WRITE_REG) || (c == CMD_RESET_CORE));
  endfunction

endpackage

// File: rtl/dbg_host_bridge_if.sv
// Bus bundle of the debug host bridge: host byte stream in (rx), response
// byte stream out (tx) and the request/completion channel to the core debug
// module. The bridge uses the slave modport; the host/core side uses master.
interface dbg_host_bridge_if;
  import dbg_pkg::*;

  logic [BYTE_W-1:0] rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic [BYTE_W-1:0] tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic              dbg_valid_o;
  logic              dbg_ready_i;
  logic [CMD_W-1:0]  dbg_cmd_o;
  logic [ADDR_W-1:0] dbg_addr_o;
  logic [DATA_W-1:0] dbg_wdata_o;
  logic              dbg_done_i;
  logic [DATA_W-1:0] dbg_rdata_i;

  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i, dbg_ready_i, dbg_done_i, dbg_rdata_i,
    output rx_ready_o, tx_data_o, tx_valid_o, dbg_valid_o, dbg_cmd_o, dbg_addr_o,
           dbg_wdata_o
  );

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i, dbg_ready_i, dbg_done_i, dbg_rdata_i,
    input  rx_ready_o, tx_data_o, tx_valid_o, dbg_valid_o, dbg_cmd_o, dbg_addr_o,
           dbg_wdata_o
  );

endinterface

// File: rtl/dbg_host_bridge.sv
// Debug host bridge: parses host command bytes, issues one request to the core
// debug module, waits (bounded by TIMEOUT_CYC) for completion and serializes
// the response bytes back to the host.
// Ports: clk, rstn_i (async active-low), bus (dbg_host_bridge_if.slave).
module dbg_host_bridge
  import dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rstn_i,
  dbg_host_bridge_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t state_q, state_d;

  logic              rx_ready_q, rx_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              dbg_valid_q, dbg_valid_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;  // rx data byte or tx response byte index
  logic [1:0]        last_q, last_d;          // index of final response byte
  logic [CNT_W-1:0]  tmo_q, tmo_d;

  logic rx_fire;
  logic tx_fire;

  assign rx_fire = rx_ready_q & bus.rx_valid_i;
  assign tx_fire = tx_valid_q & bus.tx_ready_i;

  // State register
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, datapath and registered-output next values
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    byte_cnt_d  = byte_cnt_q;
    last_d      = last_q;
    tmo_d       = tmo_q;
    tx_data_d   = tx_data_q;

    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          byte_cnt_d = 2'd0;
          if (is_cmd(bus.rx_data_i)) begin
            cmd_d = bus.rx_data_i[CMD_W-1:0];
            if ((bus.rx_data_i[CMD_W-1:0] == CMD_READ_REG) ||
                (bus.rx_data_i[CMD_W-1:0] == CMD_WRITE_REG)) state_d = GET_ADDR;
            else                                             state_d = ISSUE;
          end else begin
            resp_d  = {24'd0, RESP_ERR};
            last_d  = 2'd0;
            state_d = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (rx_fire) begin
          addr_d     = bus.rx_data_i[ADDR_W-1:0];
          byte_cnt_d = 2'd0;
          state_d    = (cmd_q == CMD_WRITE_REG) ? GET_DATA : ISSUE;
        end
      end
      GET_DATA: begin
        // Little-endian assembly: first byte lands in bits [7:0]
        if (rx_fire) begin
          wdata_d[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.dbg_ready_i) begin
          tmo_d   = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // Completion is checked first so a done on the last timeout cycle wins
        if (bus.dbg_done_i) begin
          byte_cnt_d = 2'd0;
          state_d    = SEND;
          if (cmd_q == CMD_READ_REG) begin
            resp_d = bus.dbg_rdata_i;
            last_d = 2'd3;
          end else begin
            resp_d = {24'd0, RESP_ACK};
            last_d = 2'd0;
          end
        end else if (tmo_q == CNT_LAST) begin
          byte_cnt_d = 2'd0;
          resp_d     = {24'd0, RESP_ERR};
          last_d     = 2'd0;
          state_d    = SEND;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      SEND: begin
        if (tx_fire) begin
          if (byte_cnt_q == last_q) state_d = IDLE;
          else                      byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    rx_ready_d  = (state_d == IDLE) || (state_d == GET_ADDR) || (state_d == GET_DATA);
    dbg_valid_d = (state_d == ISSUE);
    tx_valid_d  = (state_d == SEND);
    // Inline response serializer: present the byte selected by the next index
    if (state_d == SEND) tx_data_d = resp_d[{byte_cnt_d, 3'b000} +: 8];
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      dbg_valid_q <= 1'b0;
      cmd_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
      byte_cnt_q  <= '0;
      last_q      <= '0;
      tmo_q       <= '0;
    end else begin
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      dbg_valid_q <= dbg_valid_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
      byte_cnt_q  <= byte_cnt_d;
      last_q      <= last_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.rx_ready_o  = rx_ready_q;
  assign bus.tx_valid_o  = tx_valid_q;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.dbg_valid_o = dbg_valid_q;
  assign bus.dbg_cmd_o   = cmd_q;
  assign bus.dbg_addr_o  = addr_q;
  assign bus.dbg_wdata_o = wdata_q;

endmodule

// File: tb/tb_dbg_host_bridge.sv
// Directed self-checking bench for dbg_host_bridge (TIMEOUT_CYC = 8).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, where registered outputs are stable.
module tb_dbg_host_bridge;

  logic clk;
  logic rstn_i;
  int   checks = 0;
  int   errors = 0;

  dbg_host_bridge_if bus ();

  dbg_host_bridge #(.TIMEOUT_CYC(8)) dut (
    .clk    (clk),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one host byte; ok=1 once it was taken within the budget
  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus.rx_ready_o;
      step();
    end
    bus.rx_valid_i = 1'b0;
  endtask

  // Accept one response byte with tx_ready held high
  task automatic recv_byte(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'h00;
    bus.tx_ready_i = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.tx_valid_o) begin
        d  = bus.tx_data_o;
        ok = 1'b1;
      end
      step();
    end
    bus.tx_ready_i = 1'b0;
  endtask

  // Wait for a core request to be presented
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.dbg_valid_o) ok = 1'b1;
      else step();
    end
  endtask

  // Complete the dbg handshake, then pulse done after 'dly' cycles
  task automatic core_complete(input int dly, input logic [31:0] rdata);
    bus.dbg_ready_i = 1'b1;
    step();
    bus.dbg_ready_i = 1'b0;
    repeat (dly) step();
    bus.dbg_done_i  = 1'b1;
    bus.dbg_rdata_i = rdata;
    step();
    bus.dbg_done_i  = 1'b0;
    bus.dbg_rdata_i = 32'h0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (2) step();
    checks++;
    if ({bus.rx_ready_o, bus.tx_valid_o, bus.dbg_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_valids: got %b want 000",
               {bus.rx_ready_o, bus.tx_valid_o, bus.dbg_valid_o});
    end
    checks++;
    if ({bus.tx_data_o, bus.dbg_cmd_o, bus.dbg_addr_o, bus.dbg_wdata_o} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: tx=%h cmd=%h addr=%h wdata=%h want all 0",
               bus.tx_data_o, bus.dbg_cmd_o, bus.dbg_addr_o, bus.dbg_wdata_o);
    end
    rstn_i = 1'b1;
    step();
    checks++;
    if (bus.rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rx_ready: got %b want 1", bus.rx_ready_o);
    end
  endtask

  task automatic test_halt();
    bit ok;
    logic [7:0] d;
    // Stray completion while idle must be ignored
    bus.dbg_done_i = 1'b1;
    step();
    bus.dbg_done_i = 1'b0;
    step();
    checks++;
    if ({bus.tx_valid_o, bus.dbg_valid_o, bus.rx_ready_o} !== 3'b001) begin
      errors++;
      $display("FAIL idle_done_ignored: tx_v,dbg_v,rx_r=%b want 001",
               {bus.tx_valid_o, bus.dbg_valid_o, bus.rx_ready_o});
    end
    // Cycle n: HALT accepted, core always ready
    bus.rx_data_i   = 8'h01;
    bus.rx_valid_i  = 1'b1;
    bus.dbg_ready_i = 1'b1;
    step();
    bus.rx_valid_i = 1'b0;
    checks++;
    if ({bus.dbg_valid_o, bus.dbg_cmd_o, bus.tx_valid_o, bus.rx_ready_o} !== 6'b1_001_0_0) begin
      errors++;
      $display("FAIL halt_n1: dbg_v=%b cmd=%0d tx_v=%b rx_r=%b want 1 1 0 0",
               bus.dbg_valid_o, bus.dbg_cmd_o, bus.tx_valid_o, bus.rx_ready_o);
    end
    step();
    bus.dbg_ready_i = 1'b0;
    bus.dbg_done_i  = 1'b1;
    checks++;
    if ({bus.dbg_valid_o, bus.tx_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL halt_n2: dbg_v=%b tx_v=%b want 0 0", bus.dbg_valid_o, bus.tx_valid_o);
    end
    step();
    bus.dbg_done_i = 1'b0;
    checks++;
    if ({bus.tx_valid_o, bus.tx_data_o} !== {1'b1, 8'hAA}) begin
      errors++;
      $display("FAIL halt_n3: tx_v=%b tx_data=%h want 1 aa", bus.tx_valid_o, bus.tx_data_o);
    end
    recv_byte(d, ok);
    checks++;
    if (!ok || d !== 8'hAA || bus.tx_valid_o !== 1'b0 || bus.rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL halt_resp: ok=%b byte=%h tx_v=%b rx_r=%b want 1 aa 0 1",
               ok, d, bus.tx_valid_o, bus.rx_ready_o);
    end
  endtask

  task automatic test_write_reg();
    bit ok, all_ok;
    logic [7:0] d;
    logic [7:0] frame [6];
    frame = '{8'h04, 8'h0A, 8'h78, 8'h56, 8'h34, 8'h12};
    all_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_byte(frame[i], ok);
      all_ok &= ok;
    end
    wait_req(ok);
    all_ok &= ok;
    checks++;
    if (!all_ok || bus.dbg_cmd_o !== 3'd4 || bus.dbg_addr_o !== 5'd10 ||
        bus.dbg_wdata_o !== 32'h12345678 || bus.rx_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL write_req: ok=%b cmd=%0d addr=%0d wdata=%h rx_r=%b want 1 4 10 12345678 0",
               all_ok, bus.dbg_cmd_o, bus.dbg_addr_o, bus.dbg_wdata_o, bus.rx_ready_o);
    end
    // Request must hold while the core stalls
    repeat (3) step();
    checks++;
    if (bus.dbg_valid_o !== 1'b1 || bus.dbg_wdata_o !== 32'h12345678 || bus.dbg_addr_o !== 5'd10) begin
      errors++;
      $display("FAIL write_hold: dbg_v=%b addr=%0d wdata=%h want 1 10 12345678",
               bus.dbg_valid_o, bus.dbg_addr_o, bus.dbg_wdata_o);
    end
    core_complete(1, 32'h0);
    recv_byte(d, ok);
    checks++;
    if (!ok || d !== 8'hAA) begin
      errors++;
      $display("FAIL write_resp: ok=%b byte=%h want 1 aa", ok, d);
    end
  endtask

  task automatic test_read_reg();
    bit ok, all_ok;
    bit tr;
    int got;
    logic [7:0] rb [4];
    logic [7:0] exp_b [4];
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rb    = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_byte(8'h03, all_ok);
    send_byte(8'h05, ok);
    all_ok &= ok;
    wait_req(ok);
    all_ok &= ok;
    checks++;
    if (!all_ok || bus.dbg_cmd_o !== 3'd3 || bus.dbg_addr_o !== 5'd5) begin
      errors++;
      $display("FAIL read_req: ok=%b cmd=%0d addr=%0d want 1 3 5", all_ok, bus.dbg_cmd_o, bus.dbg_addr_o);
    end
    core_complete(2, 32'hDEADBEEF);
    got = 0;
    tr  = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      tr = ~tr;
      bus.tx_ready_i = tr;
      if (bus.tx_valid_o && tr) begin
        rb[got] = bus.tx_data_o;
        got++;
      end
      step();
    end
    bus.tx_ready_i = 1'b0;
    checks++;
    if (got !== 4 || bus.tx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL read_count: got %0d bytes tx_v=%b want 4 0", got, bus.tx_valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rb[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL read_byte%0d: got %h want %h", i, rb[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    logic [7:0] d;
    send_byte(8'h02, ok);
    wait_req(ok);
    bus.dbg_ready_i = 1'b1;
    step();
    bus.dbg_ready_i = 1'b0;
    cnt = 0;
    while (bus.tx_valid_o !== 1'b1 && cnt < 50) begin
      cnt++;
      step();
    end
    checks++;
    if (!ok || cnt !== 8 || bus.tx_data_o !== 8'hEE) begin
      errors++;
      $display("FAIL timeout: ok=%b wait_cycles=%0d tx_data=%h want 1 8 ee", ok, cnt, bus.tx_data_o);
    end
    recv_byte(d, ok);
    checks++;
    if (!ok || d !== 8'hEE || bus.rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_idle: ok=%b byte=%h rx_r=%b want 1 ee 1", ok, d, bus.rx_ready_o);
    end
  endtask

  task automatic test_done_at_timeout();
    bit ok, ok2;
    logic [7:0] d;
    send_byte(8'h05, ok);
    wait_req(ok2);
    bus.dbg_ready_i = 1'b1;
    step();
    bus.dbg_ready_i = 1'b0;
    repeat (7) step();
    bus.dbg_done_i = 1'b1;
    step();
    bus.dbg_done_i = 1'b0;
    checks++;
    if (!(ok && ok2) || bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'hAA) begin
      errors++;
      $display("FAIL done_at_timeout: ok=%b tx_v=%b tx_data=%h want 1 1 aa",
               ok && ok2, bus.tx_valid_o, bus.tx_data_o);
    end
    recv_byte(d, ok);
  endtask

  task automatic test_bad_cmd();
    bit ok;
    logic [7:0] d;
    send_byte(8'h07, ok);
    checks++;
    if (!ok || bus.dbg_valid_o !== 1'b0 || bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'hEE) begin
      errors++;
      $display("FAIL bad_cmd: ok=%b dbg_v=%b tx_v=%b tx_data=%h want 1 0 1 ee",
               ok, bus.dbg_valid_o, bus.tx_valid_o, bus.tx_data_o);
    end
    recv_byte(d, ok);
    checks++;
    if (!ok || d !== 8'hEE || bus.rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bad_cmd_end: ok=%b byte=%h rx_r=%b want 1 ee 1", ok, d, bus.rx_ready_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok, all_ok;
    bit seen;
    logic [7:0] d;
    send_byte(8'h04, all_ok);
    send_byte(8'h0A, ok);
    all_ok &= ok;
    send_byte(8'h78, ok);
    all_ok &= ok;
    send_byte(8'h56, ok);
    all_ok &= ok;
    rstn_i = 1'b0;
    step();
    checks++;
    if (!all_ok || bus.rx_ready_o !== 1'b0 || bus.dbg_wdata_o !== 32'h0 || bus.dbg_addr_o !== 5'd0) begin
      errors++;
      $display("FAIL midframe_reset: ok=%b rx_r=%b addr=%0d wdata=%h want 1 0 0 0",
               all_ok, bus.rx_ready_o, bus.dbg_addr_o, bus.dbg_wdata_o);
    end
    rstn_i = 1'b1;
    step();
    checks++;
    if (bus.rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midframe_release: rx_r=%b want 1", bus.rx_ready_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_valid_o || bus.dbg_valid_o) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midframe_quiet: activity=%b want 0", seen);
    end
    send_byte(8'h01, all_ok);
    wait_req(ok);
    all_ok &= ok;
    checks++;
    if (!all_ok || bus.dbg_cmd_o !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_halt_req: ok=%b cmd=%0d want 1 1", all_ok, bus.dbg_cmd_o);
    end
    core_complete(0, 32'h0);
    recv_byte(d, ok);
    checks++;
    if (!ok || d !== 8'hAA) begin
      errors++;
      $display("FAIL post_reset_halt_resp: ok=%b byte=%h want 1 aa", ok, d);
    end
  endtask

  initial begin
    bus.rx_data_i   = 8'h00;
    bus.rx_valid_i  = 1'b0;
    bus.tx_ready_i  = 1'b0;
    bus.dbg_ready_i = 1'b0;
    bus.dbg_done_i  = 1'b0;
    bus.dbg_rdata_i = 32'h0;
    rstn_i          = 1'b0;
    #1;
    test_reset();
    test_halt();
    test_write_reg();
    test_read_reg();
    test_timeout();
    test_done_at_timeout();
    test_bad_cmd();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
